// File: rtl/quadrature_generator_pkg.sv
// Shared quadrature phase encoding, phase-step functions and FSM state type.
// Phase words are {enc_b, enc_a}; the decoder bench reuses these constants.
package quadrature_generator_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [1:0] next_fwd(input logic [1:0] ph);
    logic [1:0] nx;
    nx = PH_00;
    case (ph)
      PH_00:   nx = PH_01;
      PH_01:   nx = PH_11;
      PH_11:   nx = PH_10;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

  function automatic logic [1:0] next_rev(input logic [1:0] ph);
    logic [1:0] nx;
    nx = PH_00;
    case (ph)
      PH_00:   nx = PH_10;
      PH_10:   nx = PH_11;
      PH_11:   nx = PH_01;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quadrature_generator_if.sv
// Command/status bundle of the quadrature generator; master issues moves,
// slave (the generator) drives the encoder phases and status.
interface quadrature_generator_if #(
  parameter int WIDTH     = 16,
  parameter int PER_WIDTH = 16
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic signed [WIDTH-1:0]     cmd_steps;
  logic        [PER_WIDTH-1:0] cmd_period;
  logic                        abort;
  logic                        enc_a;
  logic                        enc_b;
  logic signed [WIDTH-1:0]     position;
  logic                        busy;
  logic                        done;

  modport master (
    output cmd_valid, cmd_steps, cmd_period, abort,
    input  cmd_ready, enc_a, enc_b, position, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_period, abort,
    output cmd_ready, enc_a, enc_b, position, busy, done
  );
endinterface

// File: rtl/quad_tick_divider.sv
// Edge-rate divider: counts 0..period-1 while enabled and fires a one-cycle
// tick on the terminal count. The period is loaded and the count cleared per move.
module quad_tick_divider #(
  parameter int PER_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clear,
  input  logic                 load,
  input  logic [PER_WIDTH-1:0] period_in,
  output logic                 tick
);

  localparam logic [PER_WIDTH-1:0] ONE = PER_WIDTH'(1);

  logic [PER_WIDTH-1:0] period_q, period_d;
  logic [PER_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en && !clear && (cnt_q == (period_q - ONE));

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (load) begin
      period_d = period_in;
    end
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= ONE;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/quadrature_generator.sv
// Encoder emulator: turns signed relative moves into a quadrature edge train
// at a programmable edge period, tracking its own signed position.
module quadrature_generator
  import quadrature_generator_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int PER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  quadrature_generator_if.slave bus
);

  localparam logic signed [WIDTH-1:0] POS_ONE = WIDTH'(1);
  localparam logic        [WIDTH-1:0] REM_ONE = WIDTH'(1);

  state_t                  state_q, state_d;
  logic [1:0]              phase_q, phase_d;
  logic signed [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic                    dir_q, dir_d;
  logic                    done_q, done_d;

  logic                    accept;
  logic                    tick;
  logic                    div_load;
  logic                    div_clear;
  logic [WIDTH-1:0]        steps_mag;
  logic [PER_WIDTH-1:0]    period_in;

  assign accept = (state_q == IDLE) && bus.cmd_valid;

  // Two's-complement negate of the most-negative value yields 2^(WIDTH-1) unsigned.
  assign steps_mag = bus.cmd_steps[WIDTH-1] ? $unsigned(-bus.cmd_steps)
                                            : $unsigned(bus.cmd_steps);
  assign period_in = (bus.cmd_period == '0) ? PER_WIDTH'(1) : bus.cmd_period;

  quad_tick_divider #(
    .PER_WIDTH (PER_WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q == RUN),
    .clear     (div_clear),
    .load      (div_load),
    .period_in (period_in),
    .tick      (tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    div_load  = 1'b0;
    div_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (steps_mag == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = RUN;
            dir_d     = bus.cmd_steps[WIDTH-1];
            rem_d     = steps_mag;
            div_load  = 1'b1;
            div_clear = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort wins over a coincident tick so no edge follows the abort.
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          phase_d = dir_q ? next_rev(phase_q) : next_fwd(phase_q);
          pos_d   = dir_q ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_00;
      pos_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.enc_a     = phase_q[0];
  assign bus.enc_b     = phase_q[1];
  assign bus.position  = pos_q;

endmodule
